// File: rtl/div_pkg.sv
// Purpose : shared constants and types for the 16-bit sequential divider.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DIV_WIDTH     default operand/result width
//   DIV_CNT_W     iteration counter width (log2 of DIV_WIDTH)
//   state_e       FSM state encodings IDLE/CALC/DONE
//   DBZ_QUOTIENT  quotient reported for a zero divisor
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/div_sub_stage.sv
// Purpose : one restoring-division trial subtraction (trial remainder - divisor).
// Latency : purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle by the owning FSM.
//
// Ports:
//   i_prem    [WIDTH:0]   17-bit trial partial remainder {R, next dividend bit}
//   i_divisor [WIDTH-1:0] divisor
//   o_diff    [WIDTH-1:0] trial - divisor (meaningful only when o_ge=1)
//   o_ge      1           trial >= divisor
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_prem,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_ge
);

  // The 17-bit subtraction is split: the low 16 bits plus a borrow out, and
  // the trial MSB handled separately. A set trial MSB means the trial is at
  // least 2^16, which always exceeds a 16-bit divisor. When the result is
  // kept it is smaller than the divisor, so its low 16 bits are the whole
  // difference.
  logic [WIDTH:0] w_low_sub;

  assign w_low_sub = {1'b0, i_prem[WIDTH-1:0]} - {1'b0, i_divisor};
  assign o_ge      = i_prem[WIDTH] | ~w_low_sub[WIDTH];
  assign o_diff    = w_low_sub[WIDTH-1:0];

endmodule

// File: rtl/div16_seq.sv
// Purpose : iterative restoring divider, one quotient bit per cycle, MSB first.
// Latency : done 17 cycles after start is accepted (1 cycle for divisor=0).
// Backpressure: start only sampled in IDLE; ignored while busy or during done.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start                   request pulse, sampled in IDLE only
//   i_dividend, i_divisor     operands, captured when start is accepted
//   o_busy                    high in CALC and DONE
//   o_done                    one-cycle pulse, results valid
//   o_quotient, o_remainder   registered results, held until next accepted start
//   o_div_by_zero             set with the results when the divisor was zero
module div16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CNT_W = DIV_CNT_W;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prem;     // partial remainder, always < divisor between iterations
  logic [WIDTH-1:0] r_dvd;      // dividend bits shift out of the MSB, quotient bits into the LSB
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_prem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last_iter;
  logic             w_accept;
  logic             w_dvs_zero;
  logic             w_busy;
  logic             w_done;

  // ---------------------------------------------------------------------------
  // Datapath: one trial subtraction per CALC cycle
  // ---------------------------------------------------------------------------
  assign w_trial     = {r_prem, r_dvd[WIDTH-1]};
  assign w_prem_nxt  = w_ge ? w_diff : w_trial[WIDTH-1:0];
  assign w_quo_nxt   = {r_dvd[WIDTH-2:0], w_ge};
  assign w_last_iter = (r_cnt == LAST_ITER);
  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_dvs_zero  = (i_divisor == '0);

  div_sub_stage #(
    .WIDTH (WIDTH)
  ) u_sub (
    .i_prem    (w_trial),
    .i_divisor (r_dvs),
    .o_diff    (w_diff),
    .o_ge      (w_ge)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          // A zero divisor needs no iterations; results are known immediately.
          w_state_nxt = w_dvs_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last_iter) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_CALC: begin
        w_busy = 1'b1;
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, working registers and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_prem <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_prem <= '0;
        r_dvd  <= i_dividend;
        r_dvs  <= i_divisor;
        if (w_dvs_zero) begin
          // Entry to DONE straight from IDLE: results are fixed by definition.
          r_quo <= DBZ_QUOTIENT;
          r_rem <= i_dividend;
          r_dbz <= 1'b1;
        end
      end else if (r_state == ST_CALC) begin
        r_cnt  <= r_cnt + 1'b1;
        r_prem <= w_prem_nxt;
        r_dvd  <= w_quo_nxt;
        if (w_last_iter) begin
          // Results are published only as the FSM enters DONE, so the
          // outputs stay stable through the whole CALC phase.
          r_quo <= w_quo_nxt;
          r_rem <= w_prem_nxt;
          r_dbz <= 1'b0;
        end
      end
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = w_done;
  assign o_quotient    = r_quo;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div16_seq.sv
// Purpose : directed and random checks of div16_seq against a scoreboard.
// Latency : measures done latency from the accepting edge for each request.
// Backpressure: drives start during busy and during done to confirm it is ignored.
module tb_div16_seq;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;
  logic        o_div_by_zero;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  div16_seq #(.WIDTH(16)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r,
                              input logic dbz, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
    return e;
  endfunction

  // Reference model for the random regression.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return mk(16'hFFFF, a, 1'b1, 1);
    return mk(a / b, a % b, 1'b0, 17);
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // Called at a negedge: pushes the expectation and pulses start for one cycle,
  // then scrambles the operands to show they are not re-sampled.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    sb.push_back(e);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    @(negedge i_clk);
    i_start    = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
  endtask

  // lat counts cycles after the accepting edge; bounded so the run never hangs.
  task automatic wait_done(output int lat);
    lat = 1;
    while (o_done !== 1'b1 && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic finish_op(input string tag, input int lat);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(o_done), 32'(1'b1));
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_quo"}, 32'(o_quotient), 32'(e.q));
    chk({tag, "_rem"}, 32'(o_remainder), 32'(e.r));
    chk({tag, "_dbz"}, 32'(o_div_by_zero), 32'(e.dbz));
    // A start in the done cycle (with a zero divisor, which would otherwise
    // produce an immediate second done) must be ignored.
    i_start    = 1'b1;
    i_dividend = 16'h0055;
    i_divisor  = 16'h0000;
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, "_gap"}, 32'({o_done, o_busy}), 32'(2'b00));
    chk({tag, "_hold"}, {o_quotient, o_remainder}, {e.q, e.r});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] a;
    logic [15:0] b;

    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_dividend = 16'd0;
    i_divisor  = 16'd0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_quo", 32'(o_quotient), 32'd0);
    chk("rst_rem", 32'(o_remainder), 32'd0);
    chk("rst_dbz", 32'(o_div_by_zero), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    launch(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 17));
    wait_done(lat);
    finish_op("d100_7", lat);

    launch(16'hFFFF, 16'd1, mk(16'hFFFF, 16'd0, 1'b0, 17));
    wait_done(lat);
    finish_op("dFFFF_1", lat);

    launch(16'd3, 16'd10, mk(16'd0, 16'd3, 1'b0, 17));
    wait_done(lat);
    finish_op("d3_10", lat);

    launch(16'd1234, 16'd0, mk(16'hFFFF, 16'd1234, 1'b1, 1));
    wait_done(lat);
    finish_op("d1234_0", lat);

    launch(16'hFFFF, 16'hFFFE, mk(16'd1, 16'd1, 1'b0, 17));
    wait_done(lat);
    finish_op("dFFFF_FFFE", lat);

    // Second request while busy must not disturb the first.
    launch(16'd500, 16'd3, mk(16'd166, 16'd2, 1'b0, 17));
    lat = 1;
    while (o_done !== 1'b1 && lat < 40) begin
      if (lat == 5) begin
        i_start    = 1'b1;
        i_dividend = 16'd9;
        i_divisor  = 16'd9;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      lat++;
    end
    i_start = 1'b0;
    finish_op("busy_ign", lat);

    // Reset in the middle of CALC aborts the operation.
    launch(16'd200, 16'd7, mk(16'd28, 16'd4, 1'b0, 17));
    void'(sb.pop_back());
    repeat (7) @(negedge i_clk);
    chk("mid_busy_pre", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    chk("mid_rst_quo", 32'(o_quotient), 32'd0);
    chk("mid_rst_rem", 32'(o_remainder), 32'd0);
    chk("mid_rst_dbz", 32'(o_div_by_zero), 32'd0);
    @(negedge i_clk);
    chk("mid_rst_done2", 32'(o_done), 32'd0);
    // Start presented together with the reset release is accepted at once.
    i_rst_n = 1'b1;
    launch(16'd40, 16'd6, mk(16'd6, 16'd4, 1'b0, 17));
    wait_done(lat);
    finish_op("post_rst", lat);

    for (int n = 0; n < 2000; n++) begin
      a = pick16();
      b = pick16();
      launch(a, b, model(a, b));
      wait_done(lat);
      finish_op($sformatf("rnd_%0h_%0h", a, b), lat);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
